// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: lamp codes, controller
// states and the phase-index width helper.
package traffic_pkg;

  // Two-bit code driven to each phase's lamp driver
  typedef enum logic [1:0] {
    LAMP_RED    = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_GREEN  = 2'b10
  } lamp_e;

  // Controller interval currently being timed
  typedef enum logic [1:0] {
    ST_GREEN   = 2'b00,
    ST_YELLOW  = 2'b01,
    ST_ALL_RED = 2'b10
  } ctrl_state_e;

  // Bits needed to index a phase; never less than one
  function automatic int unsigned phase_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Sensor/lamp bundle of the traffic phase controller.
//   request      : synchronised demand level per phase (into controller)
//   lights       : lamp code per phase, phase i at bits [2i+1:2i]
//   active_phase : phase owning green/yellow, or the one last cleared
//   ctrl_state   : GREEN / YELLOW / ALL_RED
//   phase_start  : one-cycle pulse in the first cycle of each green
//   pending      : latched demand bits
// master = controller side, slave = sensor/lamp side.
interface traffic_phase_controller_if
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned PW         = phase_width(NUM_PHASES)
);

  logic [NUM_PHASES-1:0]   request;
  logic [2*NUM_PHASES-1:0] lights;
  logic [PW-1:0]           active_phase;
  ctrl_state_e             ctrl_state;
  logic                    phase_start;
  logic [NUM_PHASES-1:0]   pending;

  modport master (
    input  request,
    output lights, active_phase, ctrl_state, phase_start, pending
  );

  modport slave (
    output request,
    input  lights, active_phase, ctrl_state, phase_start, pending
  );

endinterface

// File: rtl/phase_timer.sv
// Interval timer: counts cycles in the current controller state, holds at
// 'limit', and returns to zero on a synchronous clear or reset.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count on the next edge (state change)
//   limit        : saturation value
//   count        : registered cycle count
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != limit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase round-robin signal controller. Serves only phases with latched
// demand, bounds each green between MIN_GREEN and MAX_GREEN with extension
// while the green phase keeps requesting, then runs fixed yellow and all-red
// clearance intervals.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : request in; lights, active_phase, ctrl_state,
//                  phase_start, pending out (all registered)
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES   = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MIN_GREEN    = 8,
  parameter int unsigned MAX_GREEN    = 32,
  parameter int unsigned YELLOW_TIME  = 4,
  parameter int unsigned ALL_RED_TIME = 2
) (
  input logic                     clock,
  input logic                     reset,
  traffic_phase_controller_if.master bus
);

  localparam int unsigned PW = phase_width(NUM_PHASES);
  localparam int unsigned LW = 2 * NUM_PHASES;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

  // First phase with demand after 'cur', wrapping; 'cur' itself is tried last
  function automatic logic [PW-1:0] next_phase(input logic [NUM_PHASES-1:0] dem,
                                               input logic [PW-1:0]         cur);
    logic [PW-1:0] sel;
    logic          found;
    int unsigned   idx;
    sel   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      idx = (32'(cur) + k) % NUM_PHASES;
      if (!found && dem[PW'(idx)]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Lamp word with 'code' on phase 'ph' and red everywhere else
  function automatic logic [LW-1:0] lamp_word(input lamp_e code, input logic [PW-1:0] ph);
    return LW'(code) << {ph, 1'b0};
  endfunction

  ctrl_state_e           state;
  logic [PW-1:0]         phase;
  logic [NUM_PHASES-1:0] pend;
  logic [LW-1:0]         lights;
  logic                  phase_start;
  logic [CNT_W-1:0]      timer;

  logic [NUM_PHASES-1:0] own_mask;
  logic [NUM_PHASES-1:0] set_mask;
  logic                  other_dem;
  logic                  go_yellow;
  logic                  go_red;
  logic                  go_green;
  logic                  state_chg;
  logic [PW-1:0]         nxt_phase;
  logic [CNT_W-1:0]      timer_limit;

  // Transition decisions and demand latch inputs
  always_comb begin
    own_mask    = NUM_PHASES'(1) << phase;
    // The green phase's own request extends green and is never latched
    set_mask    = bus.request & ~((state == ST_GREEN) ? own_mask : '0);
    other_dem   = |(pend & ~own_mask);
    go_yellow   = (state == ST_GREEN) && (timer >= MIN_LAST) && other_dem &&
                  (!(|(bus.request & own_mask)) || (timer >= MAX_LAST));
    go_red      = (state == ST_YELLOW) && (timer == Y_LAST);
    go_green    = (state == ST_ALL_RED) && (timer == AR_LAST);
    state_chg   = go_yellow || go_red || go_green;
    nxt_phase   = next_phase(pend, phase);
    timer_limit = (state == ST_GREEN) ? MAX_LAST : '1;
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_chg),
    .limit (timer_limit),
    .count (timer)
  );

  // Controller state, demand latch and registered lamp outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_GREEN;
      phase       <= '0;
      pend        <= '0;
      phase_start <= 1'b0;
      lights      <= lamp_word(LAMP_GREEN, '0);
    end else begin
      phase_start <= 1'b0;
      pend        <= pend | set_mask;
      case (state)
        ST_GREEN: begin
          if (go_yellow) begin
            state  <= ST_YELLOW;
            lights <= lamp_word(LAMP_YELLOW, phase);
          end
        end
        ST_YELLOW: begin
          if (go_red) begin
            state  <= ST_ALL_RED;
            lights <= '0;
          end
        end
        ST_ALL_RED: begin
          if (go_green) begin
            state       <= ST_GREEN;
            phase       <= nxt_phase;
            phase_start <= 1'b1;
            // Entry clear wins over a same-cycle request for the new phase
            pend        <= (pend | set_mask) & ~(NUM_PHASES'(1) << nxt_phase);
            lights      <= lamp_word(LAMP_GREEN, nxt_phase);
          end
        end
        default: begin
          state  <= ST_GREEN;
          lights <= lamp_word(LAMP_GREEN, phase);
        end
      endcase
    end
  end

  assign bus.lights       = lights;
  assign bus.active_phase = phase;
  assign bus.ctrl_state   = state;
  assign bus.phase_start  = phase_start;
  assign bus.pending      = pend;

endmodule
